// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int PRESCALE_W = 19;
  // One bit period is prescale shifted left by this amount (prescale*8 clocks).
  localparam int BIT_SHIFT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for rxd plus an optional 2-of-3 majority vote over the
// last three synchronized samples (enabled by UART_RX_MAJORITY_EN).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd_i,
  output logic rxd_s_o,
  output logic rxd_vote_o
);

  logic [1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the line idles high, hence the reset value of 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
    end
  end

  assign rxd_s_o = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
    end
  end

  assign rxd_vote_o = (sync_q[1] & hist_q[0]) |
                      (sync_q[1] & hist_q[1]) |
                      (hist_q[0] & hist_q[1]);
`else
  assign rxd_vote_o = sync_q[1];
`endif

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with an AXI4-Stream byte output and one-cycle
// framing/overrun status pulses. Optional majority sampling: UART_RX_MAJORITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic rxd_s;
  logic rxd_vote;

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd_i      (rxd),
    .rxd_s_o    (rxd_s),
    .rxd_vote_o (rxd_vote)
  );

  state_e                  state_q, state_d;
  logic [PRESCALE_W-1:0]   prescale_reg_q, prescale_reg_d;
  logic [PRESCALE_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overrun_q, overrun_d;
  logic                    byte_done;
  logic [PRESCALE_W-1:0]   bit_period;

  assign bit_period = PRESCALE_W'(prescale) << BIT_SHIFT;

  // Frame sequencing: the counter expires mid-bit, where each bit is sampled.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    prescale_reg_d = prescale_reg_q;
    period_d       = period_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    frame_err_d    = 1'b0;
    byte_done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rxd_s && (prescale != 16'd0)) begin
          prescale_reg_d = (bit_period >> 1) - PRESCALE_W'(2);
          period_d       = bit_period - PRESCALE_W'(1);
          state_d        = ST_START;
        end
      end
      ST_START: begin
        if (prescale_reg_q == '0) begin
          if (rxd_vote) begin
            state_d = ST_IDLE;
          end else begin
            prescale_reg_d = period_q;
            bit_cnt_d      = CNT_W'(DATA_WIDTH);
            state_d        = ST_DATA;
          end
        end else begin
          prescale_reg_d = prescale_reg_q - PRESCALE_W'(1);
        end
      end
      ST_DATA: begin
        if (prescale_reg_q == '0) begin
          shift_d        = {rxd_vote, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d      = bit_cnt_q - CNT_W'(1);
          prescale_reg_d = period_q;
          if (bit_cnt_q == CNT_W'(1)) begin
            state_d = ST_STOP;
          end
        end else begin
          prescale_reg_d = prescale_reg_q - PRESCALE_W'(1);
        end
      end
      ST_STOP: begin
        if (prescale_reg_q == '0) begin
          if (rxd_vote) begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          prescale_reg_d = prescale_reg_q - PRESCALE_W'(1);
        end
      end
      ST_BREAK: begin
        if (rxd_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register: a completed byte always wins; overrun when it lands on
  // an unaccepted byte.
  always_comb begin
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    overrun_d = 1'b0;
    if (byte_done) begin
      tdata_d  = shift_q;
      tvalid_d = 1'b1;
      if (tvalid_q && !output_axis_tready) begin
        overrun_d = 1'b1;
      end
    end else if (tvalid_q && output_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      prescale_reg_q <= '0;
      period_q       <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      tdata_q        <= '0;
      tvalid_q       <= 1'b0;
      frame_err_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      prescale_reg_q <= prescale_reg_d;
      period_q       <= period_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      tdata_q        <= tdata_d;
      tvalid_q       <= tvalid_d;
      frame_err_q    <= frame_err_d;
      overrun_q      <= overrun_d;
    end
  end

  assign output_axis_tdata  = tdata_q;
  assign output_axis_tvalid = tvalid_q;
  assign busy               = (state_q != ST_IDLE);
  assign frame_error        = frame_err_q;
  assign overrun_error      = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: reset, single frame, back-to-back
// frames, false start, break, overrun and mid-frame reset.
module tb_uart_rx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tready;
  logic          rxd;
  logic [15:0]   prescale;
  logic [DW-1:0] tdata;
  logic          tvalid, busy, oe, fe;

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .output_axis_tdata  (tdata),
    .output_axis_tvalid (tvalid),
    .output_axis_tready (tready),
    .rxd                (rxd),
    .busy               (busy),
    .overrun_error      (oe),
    .frame_error        (fe),
    .prescale           (prescale)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor sampled on the falling edge, away from the active edge.
  logic [DW-1:0] hs_q[$];
  int   fe_cnt = 0, oe_cnt = 0, tv_cnt = 0, busy_cnt = 0, rise_cyc = -1;
  logic tvalid_prev = 1'b0;

  always @(negedge clk) begin
    if (tvalid === 1'b1 && tready === 1'b1) hs_q.push_back(tdata);
    if (fe === 1'b1) fe_cnt <= fe_cnt + 1;
    if (oe === 1'b1) oe_cnt <= oe_cnt + 1;
    if (tvalid === 1'b1) tv_cnt <= tv_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (tvalid === 1'b1 && tvalid_prev !== 1'b1) rise_cyc <= cyc;
    tvalid_prev <= tvalid;
  end

  task automatic drive_bit(input logic v, input int p);
    rxd = v;
    repeat (p * 8) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] b, input logic stop_bit, input int p);
    fall_cyc = cyc;
    drive_bit(1'b0, p);
    for (int i = 0; i < DW; i++) drive_bit(b[i], p);
    drive_bit(stop_bit, p);
  endtask

  task automatic test_reset();
    rxd = 1'b1; tready = 1'b1; prescale = 16'd1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tdata, tvalid, busy, oe, fe} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got tdata=%h tvalid=%b busy=%b oe=%b fe=%b, expected all 0",
               tdata, tvalid, busy, oe, fe);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({tvalid, busy, oe, fe} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: got tvalid=%b busy=%b oe=%b fe=%b, expected 0",
               tvalid, busy, oe, fe);
    end
  endtask

  task automatic test_single_frame();
    int hs0 = hs_q.size(), tv0 = tv_cnt, b0 = busy_cnt, fe0 = fe_cnt, oe0 = oe_cnt;
    int lat, bcyc;
    prescale = 16'd1; tready = 1'b1;
    send_frame(8'h55, 1'b1, 1);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (hs_q.size() - hs0 !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d bytes, expected 1", hs_q.size() - hs0);
    end
    checks++;
    if (hs_q.size() > hs0 && hs_q[hs0] !== 8'h55) begin
      errors++;
      $display("FAIL single_data: got %h, expected 55", hs_q[hs0]);
    end
    checks++;
    if (tv_cnt - tv0 !== 1) begin
      errors++;
      $display("FAIL single_tvalid_len: got %0d cycles, expected 1", tv_cnt - tv0);
    end
    bcyc = busy_cnt - b0;
    checks++;
    if (bcyc < 70 || bcyc > 80) begin
      errors++;
      $display("FAIL single_busy_len: got %0d cycles, expected 70..80", bcyc);
    end
    lat = rise_cyc - fall_cyc;
    checks++;
    if (lat < 78 || lat > 80) begin
      errors++;
      $display("FAIL single_latency: got %0d clocks, expected 78..80", lat);
    end
    checks++;
    if ((fe_cnt - fe0) + (oe_cnt - oe0) !== 0) begin
      errors++;
      $display("FAIL single_errors: got fe=%0d oe=%0d, expected 0", fe_cnt - fe0, oe_cnt - oe0);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_b [4] = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    int hs0 = hs_q.size(), fe0 = fe_cnt, oe0 = oe_cnt;
    prescale = 16'd4; tready = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1, 4);
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (hs_q.size() - hs0 !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d bytes, expected 4", hs_q.size() - hs0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hs_q.size() > hs0 + i && hs_q[hs0 + i] !== exp_b[i]) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %h, expected %h", i, hs_q[hs0 + i], exp_b[i]);
      end
    end
    checks++;
    if ((fe_cnt - fe0) + (oe_cnt - oe0) !== 0) begin
      errors++;
      $display("FAIL b2b_errors: got fe=%0d oe=%0d, expected 0", fe_cnt - fe0, oe_cnt - oe0);
    end
  endtask

  task automatic test_false_start();
    int hs0 = hs_q.size(), tv0 = tv_cnt, b0 = busy_cnt, fe0 = fe_cnt;
    prescale = 16'd2; tready = 1'b1;
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if ((tv_cnt - tv0) !== 0 || (hs_q.size() - hs0) !== 0) begin
      errors++;
      $display("FAIL false_start_tvalid: got %0d tvalid cycles, expected 0", tv_cnt - tv0);
    end
    checks++;
    if (fe_cnt - fe0 !== 0) begin
      errors++;
      $display("FAIL false_start_fe: got %0d pulses, expected 0", fe_cnt - fe0);
    end
    checks++;
    if ((busy_cnt - b0) < 1 || (busy_cnt - b0) > 10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL false_start_busy: got %0d busy cycles, busy=%b, expected 1..10 and 0",
               busy_cnt - b0, busy);
    end
  endtask

  task automatic test_break();
    int hs0 = hs_q.size(), tv0 = tv_cnt, fe0 = fe_cnt;
    prescale = 16'd1; tready = 1'b1;
    send_frame(8'h81, 1'b0, 1);
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL break_busy_low: got busy=%b, expected 1", busy);
    end
    rxd = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (fe_cnt - fe0 !== 1) begin
      errors++;
      $display("FAIL break_fe_count: got %0d pulses, expected 1", fe_cnt - fe0);
    end
    checks++;
    if ((tv_cnt - tv0) !== 0 || (hs_q.size() - hs0) !== 0) begin
      errors++;
      $display("FAIL break_tvalid: got %0d tvalid cycles, expected 0", tv_cnt - tv0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL break_idle: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_overrun();
    int oe0 = oe_cnt, hs0 = hs_q.size();
    prescale = 16'd1; tready = 1'b0;
    send_frame(8'h12, 1'b1, 1);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (tvalid !== 1'b1 || tdata !== 8'h12 || oe_cnt - oe0 !== 0) begin
      errors++;
      $display("FAIL overrun_first: got tvalid=%b tdata=%h oe=%0d, expected 1/12/0",
               tvalid, tdata, oe_cnt - oe0);
    end
    send_frame(8'h34, 1'b1, 1);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (oe_cnt - oe0 !== 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d pulses, expected 1", oe_cnt - oe0);
    end
    checks++;
    if (tvalid !== 1'b1 || tdata !== 8'h34) begin
      errors++;
      $display("FAIL overrun_data: got tvalid=%b tdata=%h, expected 1/34", tvalid, tdata);
    end
    tready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tvalid !== 1'b0 || hs_q.size() - hs0 !== 1) begin
      errors++;
      $display("FAIL overrun_accept: got tvalid=%b accepted=%0d, expected 0/1",
               tvalid, hs_q.size() - hs0);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    int hs0 = hs_q.size(), fe0 = fe_cnt, oe0 = oe_cnt;
    prescale = 16'd1; tready = 1'b1;
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 1);
    drive_bit(1'b0, 1);
    #2;
    rst_n = 1'b0;
    rxd = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort: got busy=%b tvalid=%b, expected 0/0", busy, tvalid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (hs_q.size() - hs0 !== 0 || fe_cnt - fe0 !== 0) begin
      errors++;
      $display("FAIL midreset_no_output: got bytes=%0d fe=%0d, expected 0/0",
               hs_q.size() - hs0, fe_cnt - fe0);
    end
    send_frame(8'h7E, 1'b1, 1);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (hs_q.size() - hs0 !== 1 || (hs_q.size() > hs0 && hs_q[hs0] !== 8'h7E)) begin
      errors++;
      $display("FAIL midreset_next_frame: got bytes=%0d first=%h, expected 1/7e",
               hs_q.size() - hs0, (hs_q.size() > hs0) ? hs_q[hs0] : 8'h00);
    end
    checks++;
    if (fe_cnt - fe0 !== 0 || oe_cnt - oe0 !== 0) begin
      errors++;
      $display("FAIL midreset_errors: got fe=%0d oe=%0d, expected 0", fe_cnt - fe0, oe_cnt - oe0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_false_start();
    test_break();
    test_overrun();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side counterpart to the team's AXI4-Stream UART transmitter. It consumes the serial line that the transmitter drives.
- Oversamples rxd using the same prescale convention as the transmitter: one bit period = prescale*8 clocks.
- Recovers 8N1-style frames and presents each received byte on an AXI4-Stream master interface.
- Reports framing and overrun errors as single-cycle status pulses.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- output_axis_tdata  output  DATA_WIDTH  received byte.
- output_axis_tvalid  output  1  byte available.
- output_axis_tready  input  1  downstream accepts the byte.
- rxd  input  1  serial line, asynchronous to clk, idle high.
- busy  output  1  a frame is in progress.
- overrun_error  output  1  one-cycle pulse: a new byte was completed while tvalid was still high.
- frame_error  output  1  one-cycle pulse: the stop bit was sampled low.
- prescale  input  16  clocks per bit divided by 8.

Behaviour:
- Reset:
  - Async, active-low. The block has one clock and no other reset.
  - Outputs on reset: tdata=0, tvalid=0, busy=0, overrun_error=0, frame_error=0.
  - Internal state on reset: synchronizer flops=1, state=IDLE, prescale_reg=0, bit_cnt=0.
  - Assertion mid-frame aborts the frame immediately. No output and no error pulse result.
- Input path:
  - rxd passes through a 2-flop synchronizer to give rxd_s.
  - All decisions below use rxd_s.
- Counting:
  - prescale_reg is 19 bits.
  - Bit period is T = prescale<<3.
  - prescale is captured at start detection and held for the whole frame.
  - prescale==0 is illegal: the block stays in IDLE and never starts a frame.
- State machine:
  - IDLE:
    - busy=0.
    - Entered when rxd_s==0 and prescale!=0.
    - Action on entry: load prescale_reg=(prescale<<2)-2, set busy=1, go to START.
  - START:
    - At prescale_reg==0, sample rxd_s (mid start bit).
    - If rxd_s==1: false start; go to IDLE with no pulse and no output.
    - Otherwise: load T-1, set bit_cnt=DATA_WIDTH, go to DATA.
  - DATA:
    - Each expiry shifts rxd_s into the MSB of a shift register (LSB-first reconstruction), decrements bit_cnt and reloads T-1.
    - When bit_cnt reaches 0: go to STOP with T-1 loaded.
  - STOP, at expiry:
    - If rxd_s==1:
      - Load the shift register into tdata and set tvalid=1 on the next cycle.
      - Go to IDLE with busy=0.
    - If rxd_s==0:
      - Pulse frame_error for one cycle and discard the byte.
      - Go to BREAK.
  - BREAK:
    - busy=1.
    - Wait until rxd_s==1, then go to IDLE. A held-low line therefore produces exactly one frame_error.
- AXI handshake:
  - tvalid stays high until a cycle with tvalid&&tready, then clears on the next edge.
  - tdata is stable while tvalid=1, except on overrun.
- Overrun:
  - Applies when a byte completes while tvalid=1 and tready=0 in the same cycle.
  - tdata is overwritten with the new byte, tvalid stays 1, and overrun_error pulses once.
  - If tready=1 in that cycle, the old byte is accepted, the new byte loads, and no overrun is reported.
- Latency: tvalid rises 2 + T*(DATA_WIDTH+1.5) + 1 clocks after the rxd falling edge, with a tolerance of ±1 clock.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every sample (start check, data bits, stop bit) is the 2-of-3 majority of rxd_s at counts 1, 0 and the previous cycle.
  - START still requires rxd_s==0 to enter, so a glitch of 1 clock or less at mid-bit is rejected.
  - Latency is unchanged.
- Undefined: single sample at expiry as described above.

Decomposition:
- uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK);
  - localparam PRESCALE_W=19;
  - the helper constant for the bit-period shift (3).
- Sub-module uart_rx_sync:
  - Contains the 2-flop synchronizer, reset to 1.
  - Contains the majority-vote history flops under UART_RX_MAJORITY_EN.
  - Outputs rxd_s and rxd_vote.

Test Plan:
- prescale=1 (8 clk/bit), tready=1, frame 0x55 driven on rxd → tvalid one cycle, tdata=0x55, busy high for ~76 clocks, no error pulses.
- Loopback from the team's uart_tx with prescale=4, bytes 0x00, 0xFF, 0xA5, 0x3C sent back-to-back → identical byte sequence out, zero error pulses.
- rxd low for 3 clocks with prescale=2 → returns to IDLE, tvalid never asserted, no frame_error.
- Frame 0x81 with stop bit driven 0, then line held low 50 clocks → exactly one frame_error pulse, no tvalid, return to IDLE after line high.
- tready=0, frames 0x12 then 0x34 → after first frame tvalid=1 with 0x12; after second overrun_error pulses once and tdata=0x34; raising tready clears tvalid next edge.
- rst_n pulsed low mid-DATA of a frame, then a clean 0x7E frame → no output from the aborted frame, then tdata=0x7E correctly.
